// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and the zero-register number.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MOV = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/seq_multiplier.sv
// DW-cycle shift-add multiplier. done and product are valid together in the cycle
// that performs the last partial-product add, so the caller can register them directly.
module seq_multiplier #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic            run_r;
  logic [CW-1:0]   cnt_r;
  logic [2*DW-1:0] acc_r;
  logic [2*DW-1:0] mcand_r;
  logic [DW-1:0]   mplier_r;
  logic [2*DW-1:0] acc_nxt_s;

  // Add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_nxt_s = acc_r;
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  assign done    = run_r && (cnt_r == CW'(DW - 1));
  assign product = acc_nxt_s;

  // Iteration registers; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*DW){1'b0}};
      mcand_r  <= {(2*DW){1'b0}};
      mplier_r <= {DW{1'b0}};
    end else if (start) begin
      run_r    <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*DW){1'b0}};
      mcand_r  <= {{DW{1'b0}}, a};
      mplier_r <= b;
    end else if (run_r) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      run_r    <= !done;
    end else begin
      run_r    <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage with write-back forwarding; the iterative multiplier on opcode 8
// exists only when MUL_EXEC_EN is defined, otherwise opcode 8 is a NOP.
module alu_exec_stage
  import exec_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          wb_en,
  output logic [AW-1:0] wb_reg,
  output logic [DW-1:0] wb_data,
  output logic          flag_z,
  output logic          flag_c,
  output logic          busy
);

  localparam logic [AW-1:0] R0_ADDR = AW'(REG_ZERO);

  logic          wb_en_r;
  logic [AW-1:0] wb_reg_r;
  logic [DW-1:0] wb_data_r;
  logic          flag_z_r;
  logic          flag_c_r;

  logic            in_ready_s;
  logic            accept_s;
  logic [DW-1:0]   op1_s;
  logic [DW-1:0]   op2_s;
  logic [DW:0]     sum_s;
  logic [DW:0]     diff_s;
  logic            alu_op_s;
  logic [DW-1:0]   alu_res_s;
  logic            alu_c_s;
  logic            mul_done_s;
  logic [2*DW-1:0] mul_prod_s;
  logic [AW-1:0]   mul_rd_s;
  logic            wr_s;
  logic [AW-1:0]   wr_reg_s;
  logic [DW-1:0]   wr_data_s;
  logic            wr_c_s;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;
  assign accept_s  = in_valid && in_ready_s;

  // Operand select: R0 is zero, a pending write-back beats the register file
  always_comb begin
    op1_s = rf_rdata1;
    op2_s = rf_rdata2;
    if (in_rs1 == R0_ADDR) begin
      op1_s = {DW{1'b0}};
    end else if (wb_en_r && (wb_reg_r != R0_ADDR) && (wb_reg_r == in_rs1)) begin
      op1_s = wb_data_r;
    end else begin
      op1_s = rf_rdata1;
    end
    if (in_rs2 == R0_ADDR) begin
      op2_s = {DW{1'b0}};
    end else if (wb_en_r && (wb_reg_r != R0_ADDR) && (wb_reg_r == in_rs2)) begin
      op2_s = wb_data_r;
    end else begin
      op2_s = rf_rdata2;
    end
  end

  assign sum_s  = {1'b0, op1_s} + {1'b0, op2_s};
  assign diff_s = {1'b0, op1_s} - {1'b0, op2_s};

  // Single-cycle ALU; MUL and opcodes 9-15 produce no single-cycle result
  always_comb begin
    alu_op_s  = 1'b1;
    alu_res_s = {DW{1'b0}};
    alu_c_s   = 1'b0;
    case (in_op)
      OP_ADD: begin alu_res_s = sum_s[DW-1:0];  alu_c_s = sum_s[DW];  end
      OP_SUB: begin alu_res_s = diff_s[DW-1:0]; alu_c_s = diff_s[DW]; end
      OP_AND: alu_res_s = op1_s & op2_s;
      OP_OR:  alu_res_s = op1_s | op2_s;
      OP_XOR: alu_res_s = op1_s ^ op2_s;
      OP_SHL: alu_res_s = op1_s << op2_s[2:0];
      OP_SHR: alu_res_s = op1_s >> op2_s[2:0];
      OP_MOV: alu_res_s = op1_s;
      default: alu_op_s = 1'b0;
    endcase
  end

`ifdef MUL_EXEC_EN
  state_e        state_r;
  logic [AW-1:0] mul_rd_r;
  logic          mul_start_s;

  assign in_ready_s  = (state_r == ST_IDLE);
  assign busy        = (state_r == ST_MUL);
  assign mul_start_s = accept_s && (in_op == OP_MUL);
  assign mul_rd_s    = mul_rd_r;

  seq_multiplier #(.DW(DW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (op1_s),
    .b       (op2_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Stay in MUL until the multiplier reports its final partial product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      mul_rd_r <= R0_ADDR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mul_start_s) begin
            state_r  <= ST_MUL;
            mul_rd_r <= in_rd;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_MUL;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready_s = 1'b1;
  assign busy       = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_prod_s = {(2*DW){1'b0}};
  assign mul_rd_s   = R0_ADDR;
`endif

  // Pick the result that writes back next cycle, if any
  always_comb begin
    wr_s      = 1'b0;
    wr_reg_s  = in_rd;
    wr_data_s = alu_res_s;
    wr_c_s    = alu_c_s;
    if (mul_done_s) begin
      wr_s      = (mul_rd_s != R0_ADDR);
      wr_reg_s  = mul_rd_s;
      wr_data_s = mul_prod_s[DW-1:0];
      wr_c_s    = |mul_prod_s[2*DW-1:DW];
    end else begin
      wr_s      = accept_s && alu_op_s && (in_rd != R0_ADDR);
    end
  end

  // Write-back pulse and flags; flags move only with a real write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_r   <= 1'b0;
      wb_reg_r  <= {AW{1'b0}};
      wb_data_r <= {DW{1'b0}};
      flag_z_r  <= 1'b0;
      flag_c_r  <= 1'b0;
    end else if (wr_s) begin
      wb_en_r   <= 1'b1;
      wb_reg_r  <= wr_reg_s;
      wb_data_r <= wr_data_s;
      flag_z_r  <= (wr_data_s == {DW{1'b0}});
      flag_c_r  <= wr_c_s;
    end else begin
      wb_en_r   <= 1'b0;
    end
  end

  assign in_ready = in_ready_s;
  assign wb_en    = wb_en_r;
  assign wb_reg   = wb_reg_r;
  assign wb_data  = wb_data_r;
  assign flag_z   = flag_z_r;
  assign flag_c   = flag_c_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural 8x8 register file.
// Multiply checks run when MUL_EXEC_EN is defined; otherwise opcode 8 is checked as a NOP.
module tb_alu_exec_stage;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic [AW-1:0] rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          wb_en;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          flag_z, flag_c, busy;

  logic [DW-1:0] rf [8];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  // Register file: bench loads, otherwise the stage's write-back at end of cycle
  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_data;
    else if (wb_en) rf[wb_reg] <= wb_data;
  end

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] init_v [8];
    int lowcnt;
    int k;
    int wbseen;
    init_v = '{8'hA5, 8'd200, 8'd100, 8'd0, 8'd99, 8'd0, 8'd0, 8'd0};
    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 8'd0;
    #2;
    for (int i = 0; i < 8; i++) load(AW'(i), init_v[i]);

    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_reg", {29'd0, wb_reg}, 32'd0);
    chk("rst_wb_data", {24'd0, wb_data}, 32'd0);
    chk("rst_flag_z", {31'd0, flag_z}, 32'd0);
    chk("rst_flag_c", {31'd0, flag_c}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD 200+100 = 300 -> 44 with carry
    issue(4'd0, 3'd3, 3'd1, 3'd2); in_valid = 1'b0;
    chk("add_wb_en", {31'd0, wb_en}, 32'd1);
    chk("add_wb_reg", {29'd0, wb_reg}, 32'd3);
    chk("add_wb_data", {24'd0, wb_data}, 32'd44);
    chk("add_flag_c", {31'd0, flag_c}, 32'd1);
    chk("add_flag_z", {31'd0, flag_z}, 32'd0);
    @(posedge clk); #1;
    chk("add_one_pulse", {31'd0, wb_en}, 32'd0);

    // SUB 5-5 into R4, then R4-R1 using forwarded R4=0 (file still holds 99)
    load(3'd1, 8'd5); load(3'd2, 8'd5);
    issue(4'd1, 3'd4, 3'd1, 3'd2);
    chk("sub0_wb_data", {24'd0, wb_data}, 32'd0);
    chk("sub0_flag_z", {31'd0, flag_z}, 32'd1);
    chk("sub0_flag_c", {31'd0, flag_c}, 32'd0);
    issue(4'd1, 3'd5, 3'd4, 3'd1); in_valid = 1'b0;
    chk("subfwd_wb_reg", {29'd0, wb_reg}, 32'd5);
    chk("subfwd_wb_data", {24'd0, wb_data}, 32'd251);
    chk("subfwd_flag_c", {31'd0, flag_c}, 32'd1);
    chk("subfwd_flag_z", {31'd0, flag_z}, 32'd0);
    @(posedge clk); #1;

    // R1=5 R2=5 R3=44 R4=0 R5=251; R0 holds junk in the file but must read as 0
    issue(4'd5, 3'd6, 3'd3, 3'd1);
    chk("shl_wb_data", {24'd0, wb_data}, 32'd128);
    issue(4'd6, 3'd7, 3'd5, 3'd2);
    chk("shr_wb_data", {24'd0, wb_data}, 32'd7);
    issue(4'd3, 3'd6, 3'd3, 3'd0);
    chk("or_r0_wb_data", {24'd0, wb_data}, 32'd44);
    issue(4'd2, 3'd7, 3'd1, 3'd6);
    chk("and_fwd2_wb_data", {24'd0, wb_data}, 32'd4);
    issue(4'd4, 3'd7, 3'd3, 3'd3);
    chk("xor_wb_data", {24'd0, wb_data}, 32'd0);
    chk("xor_flag_z", {31'd0, flag_z}, 32'd1);
    issue(4'd7, 3'd0, 3'd3, 3'd0);
    chk("mov_r0_wb_en", {31'd0, wb_en}, 32'd0);
    chk("mov_r0_flag_z", {31'd0, flag_z}, 32'd1);
    issue(4'd12, 3'd6, 3'd1, 3'd2); in_valid = 1'b0;
    chk("nop_wb_en", {31'd0, wb_en}, 32'd0);
    chk("nop_flag_z", {31'd0, flag_z}, 32'd1);
    chk("nop_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

`ifdef MUL_EXEC_EN
    // MUL 16*17 = 272: low byte 16, carry from nonzero upper byte
    load(3'd1, 8'd16); load(3'd2, 8'd17);
    issue(4'd8, 3'd6, 3'd1, 3'd2); in_valid = 1'b0;
    lowcnt = 0; k = 0;
    while (!wb_en && k < 20) begin
      if (!in_ready && busy) lowcnt++;
      @(posedge clk); #1;
      k++;
    end
    chk("mul_wb_seen", {31'd0, wb_en}, 32'd1);
    chk("mul_busy_cycles", lowcnt, 32'd8);
    chk("mul_wb_reg", {29'd0, wb_reg}, 32'd6);
    chk("mul_wb_data", {24'd0, wb_data}, 32'd16);
    chk("mul_flag_c", {31'd0, flag_c}, 32'd1);
    chk("mul_ready_at_wb", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Reset in the third multiply cycle aborts it
    issue(4'd8, 3'd7, 3'd1, 3'd2); in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mulrst_busy", {31'd0, busy}, 32'd0);
    chk("mulrst_wb_en", {31'd0, wb_en}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mulrst_in_ready", {31'd0, in_ready}, 32'd1);
    wbseen = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_en) wbseen++;
      @(posedge clk); #1;
    end
    chk("mulrst_no_wb", wbseen, 32'd0);
    issue(4'd0, 3'd3, 3'd1, 3'd2); in_valid = 1'b0;
    chk("postrst_add_wb_en", {31'd0, wb_en}, 32'd1);
    chk("postrst_add_data", {24'd0, wb_data}, 32'd33);
`else
    issue(4'd8, 3'd6, 3'd1, 3'd2); in_valid = 1'b0;
    chk("mul_off_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mul_off_busy", {31'd0, busy}, 32'd0);
    chk("mul_off_wb_en", {31'd0, wb_en}, 32'd0);
`endif

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
